// File: rtl/psum_pkg.sv
// Shared types for the psum scratchpad scheduler: drain FSM state encoding,
// one-hot grant encoding and default datapath widths.
package psum_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LAST  = 2'd2,
    ST_DONE  = 2'd3
  } drain_state_t;

  typedef enum logic [2:0] {
    GNT_NONE = 3'b000,
    GNT_WR   = 3'b001,
    GNT_RD   = 3'b010,
    GNT_DR   = 3'b100
  } gnt_t;

endpackage

// File: rtl/psum_drain_seq.sv
// Drain sequencer: walks entries 0..DEPTH-1, one per drain grant, then LAST/DONE.
// Requests a slot every DRAIN cycle; a denied slot simply holds idx.
module psum_drain_seq
  import psum_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_clear,
  input  logic                  i_start,
  input  logic                  i_gnt,
  output logic                  o_want,
  output logic [ADDR_WIDTH-1:0] o_idx,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  drain_state_t          r_state;
  drain_state_t          w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [ADDR_WIDTH-1:0] w_idx_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    if (i_clear) begin
      w_state_nxt = ST_IDLE;
      w_idx_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            w_state_nxt = ST_DRAIN;
            w_idx_nxt   = '0;
          end
        end
        ST_DRAIN: begin
          // idx parks on the last entry rather than wrapping
          if (i_gnt) begin
            if (r_idx == LAST_IDX) w_state_nxt = ST_LAST;
            else                   w_idx_nxt   = r_idx + 1'b1;
          end
        end
        ST_LAST: w_state_nxt = ST_DONE;
        ST_DONE: w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign o_want = (r_state == ST_DRAIN);
  assign o_idx  = r_idx;
  assign o_busy = (r_state != ST_IDLE);
  assign o_done = (r_state == ST_DONE);

endmodule

// File: rtl/psum_buffer_scheduler.sv
// Single-port psum scratchpad arbiter: write > read > drain, drain forced after STARVE_LIMIT denials.
// Grants are combinational; read and drain data return one cycle after the grant.
module psum_buffer_scheduler
  import psum_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DEPTH        = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_gnt,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  drain_start,
  output logic                  drain_valid,
  output logic [DATA_WIDTH-1:0] drain_data,
  output logic [ADDR_WIDTH-1:0] drain_idx,
  output logic                  drain_done,
  output logic                  busy,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int              SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);

  gnt_t                  w_gnt;
  logic                  w_block;
  logic                  w_drain_want;
  logic                  w_drain_gnt;
  logic [ADDR_WIDTH-1:0] w_drain_idx;
  logic [SW-1:0]         r_starve_cnt;
  logic                  r_rd_vld;
  logic                  r_drain_vld;
  logic [ADDR_WIDTH-1:0] r_drain_idx;

  psum_drain_seq #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_drain_seq (
    .clk     (clk),
    .reset   (reset),
    .i_clear (clear),
    .i_start (drain_start),
    .i_gnt   (w_drain_gnt),
    .o_want  (w_drain_want),
    .o_idx   (w_drain_idx),
    .o_busy  (busy),
    .o_done  (drain_done)
  );

  assign w_block = reset | clear;

  always_comb begin
    w_gnt = GNT_NONE;
    if (!w_block) begin
      if (w_drain_want && (r_starve_cnt == STARVE_MAX)) w_gnt = GNT_DR;
      else if (wr_req)                                  w_gnt = GNT_WR;
      else if (rd_req)                                  w_gnt = GNT_RD;
      else if (w_drain_want)                            w_gnt = GNT_DR;
    end
  end

  assign wr_gnt      = (w_gnt == GNT_WR);
  assign rd_gnt      = (w_gnt == GNT_RD);
  assign w_drain_gnt = (w_gnt == GNT_DR);

  always_comb begin
    mem_en    = (w_gnt != GNT_NONE);
    mem_we    = (w_gnt == GNT_WR);
    mem_addr  = '0;
    mem_wdata = '0;
    case (w_gnt)
      GNT_WR: begin
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
      end
      GNT_RD:  mem_addr = rd_addr;
      GNT_DR:  mem_addr = w_drain_idx;
      default: mem_addr = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve_cnt <= '0;
      r_rd_vld     <= 1'b0;
      r_drain_vld  <= 1'b0;
      r_drain_idx  <= '0;
    end else if (clear) begin
      r_starve_cnt <= '0;
      r_rd_vld     <= 1'b0;
      r_drain_vld  <= 1'b0;
      r_drain_idx  <= '0;
    end else begin
      r_rd_vld    <= rd_gnt;
      r_drain_vld <= w_drain_gnt;
      if (w_drain_gnt) r_drain_idx <= w_drain_idx;
      // cannot pass STARVE_MAX: at the limit the drain is granted and the count clears
      if (w_drain_gnt)       r_starve_cnt <= '0;
      else if (w_drain_want) r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  // SRAM output is only meaningful in the cycle after a read-type grant
  assign rd_valid    = r_rd_vld;
  assign rd_data     = r_rd_vld ? mem_rdata : '0;
  assign drain_valid = r_drain_vld;
  assign drain_data  = r_drain_vld ? mem_rdata : '0;
  assign drain_idx   = r_drain_idx;

endmodule

// File: tb/tb_psum_buffer_scheduler.sv
// Directed bench for psum_buffer_scheduler with a registered-read SRAM model.
module tb_psum_buffer_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        wr_req = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        wr_gnt;
  logic        rd_req = 1'b0;
  logic [3:0]  rd_addr = '0;
  logic        rd_gnt;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        drain_start = 1'b0;
  logic        drain_valid;
  logic [15:0] drain_data;
  logic [3:0]  drain_idx;
  logic        drain_done;
  logic        busy;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;

  logic [15:0] sram [16];

  int n_total = 0;
  int n_bad   = 0;

  psum_buffer_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_gnt      (wr_gnt),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_gnt      (rd_gnt),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .drain_start (drain_start),
    .drain_valid (drain_valid),
    .drain_data  (drain_data),
    .drain_idx   (drain_idx),
    .drain_done  (drain_done),
    .busy        (busy),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata      <= sram[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [15:0] d);
    wr_req  = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    check("preload_wr_gnt", wr_gnt, 1);
    tick();
    wr_req = 1'b0;
  endtask

  initial begin
    bit seen_done;

    // reset state
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_drain_valid", drain_valid, 0);
    check("rst_drain_done", drain_done, 0);
    tick();
    reset = 1'b0;

    // write addr 3 then read it back
    wr_req = 1'b1; wr_addr = 4'd3; wr_data = 16'h00AB;
    @(negedge clk);
    check("t1_wr_gnt", wr_gnt, 1);
    check("t1_mem_we", mem_we, 1);
    check("t1_mem_addr", mem_addr, 3);
    check("t1_mem_wdata", mem_wdata, 16'h00AB);
    tick();
    wr_req = 1'b0; rd_req = 1'b1; rd_addr = 4'd3;
    @(negedge clk);
    check("t1_rd_gnt", rd_gnt, 1);
    check("t1_rd_mem_we", mem_we, 0);
    check("t1_rd_mem_addr", mem_addr, 3);
    tick();
    rd_req = 1'b0;
    @(negedge clk);
    check("t1_rd_valid", rd_valid, 1);
    check("t1_rd_data", rd_data, 16'h00AB);

    // same-address write and read collide: write first, read returns new value
    tick();
    do_write(4'd5, 16'h0001);
    wr_req = 1'b1; wr_addr = 4'd5; wr_data = 16'h0002;
    rd_req = 1'b1; rd_addr = 4'd5;
    @(negedge clk);
    check("t2_wr_gnt", wr_gnt, 1);
    check("t2_rd_denied", rd_gnt, 0);
    tick();
    wr_req = 1'b0;
    @(negedge clk);
    check("t2_rd_gnt", rd_gnt, 1);
    tick();
    rd_req = 1'b0;
    @(negedge clk);
    check("t2_rd_valid", rd_valid, 1);
    check("t2_rd_data", rd_data, 16'h0002);
    tick();

    // preload i*2 and drain with no PE traffic
    for (int i = 0; i < 16; i++) do_write(4'(i), 16'(i * 2));
    drain_start = 1'b1;
    @(negedge clk);
    check("t3_busy_at_start", busy, 0);
    tick();
    drain_start = 1'b0;
    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      if (k <= 15) check("t3_mem_addr", mem_addr, 32'(k));
      if (k >= 1 && k <= 16) begin
        check("t3_drain_valid", drain_valid, 1);
        check("t3_drain_idx", drain_idx, 32'(k - 1));
        check("t3_drain_data", drain_data, 32'((k - 1) * 2));
      end else begin
        check("t3_drain_valid_low", drain_valid, 0);
      end
      check("t3_drain_done", drain_done, (k == 17) ? 1 : 0);
      check("t3_busy", busy, (k == 18) ? 0 : 1);
      tick();
    end

    // continuous write during drain: drain forced through every 5th cycle
    wr_req = 1'b1; wr_addr = 4'd9; wr_data = 16'h0055; drain_start = 1'b1;
    @(negedge clk);
    check("t4_wr_gnt_idle", wr_gnt, 1);
    tick();
    drain_start = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      check("t4_wr_gnt", wr_gnt, (k % 5 == 4) ? 0 : 1);
      if (k % 5 == 4) begin
        check("t4_dr_mem_we", mem_we, 0);
        check("t4_dr_mem_addr", mem_addr, 32'(k / 5));
      end
      check("t4_drain_valid", drain_valid, (k % 5 == 0 && k > 0) ? 1 : 0);
      tick();
    end

    // clear mid-drain with a pending write
    clear = 1'b1;
    @(negedge clk);
    check("t6_clr_wr_gnt", wr_gnt, 0);
    check("t6_clr_mem_en", mem_en, 0);
    tick();
    clear = 1'b0;
    @(negedge clk);
    check("t6_wr_gnt_after", wr_gnt, 1);
    check("t6_busy_after", busy, 0);
    check("t6_drain_valid_after", drain_valid, 0);
    tick();
    wr_req = 1'b0;

    // reset when drain_idx reaches 7
    drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    @(negedge clk);
    check("t5_pre_drain_idx", drain_idx, 7);
    check("t5_pre_drain_data", drain_data, 14);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("t5_busy", busy, 0);
    check("t5_drain_valid", drain_valid, 0);
    check("t5_drain_idx", drain_idx, 0);
    check("t5_drain_data", drain_data, 0);
    check("t5_drain_done", drain_done, 0);
    check("t5_mem_en", mem_en, 0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t5_no_done", drain_done, 0);
      check("t5_idle", busy, 0);
      tick();
    end
    drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    @(negedge clk);
    check("t5_restart_mem_en", mem_en, 1);
    check("t5_restart_addr", mem_addr, 0);
    tick();
    @(negedge clk);
    check("t5_restart_valid", drain_valid, 1);
    check("t5_restart_idx", drain_idx, 0);
    check("t5_restart_data", drain_data, 0);
    seen_done = 1'b0;
    for (int k = 0; k < 40 && !seen_done; k++) begin
      tick();
      @(negedge clk);
      if (drain_done) seen_done = 1'b1;
    end
    check("t5_restart_done_seen", seen_done, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
